lcd_arbiter: RTL and testbench
==============================

LCD_ARBITER -- requirements
Module: lcd_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 1024, GRANT-state cycles without valid before grant is revoked.
REQ-002 SHALL have port: clock  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: internal_reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port: req  in  2  req[i] high means requester i wants the LCD for one message.
REQ-005 SHALL have port: valid  in  2  valid[i] high means requester i presents a byte.
REQ-006 SHALL have port: last  in  2  last[i] high means requester i's presented byte ends its message.
REQ-007 SHALL have ports: data0, data1  in  8 each  byte from requester 0/1.
REQ-008 SHALL have ports: rs0, rs1  in  1 each  register-select from requester 0/1 (0 command, 1 character).
REQ-009 SHALL have port: grant  out  2  one-hot or zero, owner of the LCD.
REQ-010 SHALL have port: accept  out  2  one-cycle pulse, byte of requester i taken by the LCD.
REQ-011 SHALL have port: abort  out  1  one-cycle pulse, grant revoked by timeout or req drop.
REQ-012 SHALL have port: lcd_busy  in  1  busy flag from LCD driver.
REQ-013 SHALL have ports: lcd_data  out  8, lcd_rs  out  1  registered byte/RS to LCD driver.
REQ-014 SHALL have port: data_ready  out  1  byte on lcd_data/lcd_rs is valid for the LCD driver.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT, ISSUE, WAIT_DONE.
REQ-016 IDLE: grant=0; any req high -> GRANT next cycle with grant set to chosen requester.
REQ-017 Arbitration SHALL be round-robin: both req high -> grant requester not served last; single req -> that requester.
REQ-018 Last-served pointer SHALL update only when a grant ends (message complete or abort).
REQ-019 GRANT: valid[g] high and lcd_busy low -> latch data_g/rs_g/last[g] into lcd_data/lcd_rs/last_q, go ISSUE.
REQ-020 GRANT: valid[g] high with lcd_busy high -> remain GRANT, no latch.
REQ-021 GRANT: req[g] low and valid[g] low -> IDLE, abort pulse, grant cleared same transition.
REQ-022 GRANT: idle counter increments each cycle valid[g] is low; reaching TIMEOUT-1 -> IDLE with abort pulse; counter clears on entering GRANT.
REQ-023 ISSUE: data_ready=1, lcd_data/lcd_rs held stable; lcd_busy high -> WAIT_DONE, accept[g] pulse same cycle, data_ready low from next cycle.
REQ-024 WAIT_DONE: data_ready=0; lcd_busy low -> IDLE if last_q else GRANT (same owner, counter cleared).
REQ-025 req/valid changes during ISSUE and WAIT_DONE SHALL be ignored; a started byte always completes.
REQ-026 grant SHALL stay constant from GRANT entry until return to IDLE; messages never interleave.
REQ-027 Latency: req high in IDLE with LCD free -> data_ready high no earlier than 2 cycles later.
REQ-028 Timeout counter width SHALL be ceil(log2(TIMEOUT)) bits, saturating never exceeded.

Reset
REQ-029 internal_reset high SHALL, at the next edge, force IDLE, grant=0, accept=0, abort=0, data_ready=0, lcd_data=0, lcd_rs=0, counter=0, pointer=1 (requester 0 wins first tie).
REQ-030 Reset SHALL take priority over every transition, including mid-ISSUE/WAIT_DONE; the interrupted byte is dropped without accept.

Structure
REQ-031 State encoding and requester-count constant SHALL live in shared package lcd_pkg.
REQ-032 Round-robin selection SHALL be a sub-module rr_pick2 (inputs req, pointer; output one-hot choice).

Verification
REQ-033 Single message: req[0]=1, 3 bytes 0x38,0x0C,0x41 (last on 0x41), driver busy 5 cycles each -> three data_ready/accept[0] pulses in order, then IDLE, grant=0.
REQ-034 Contention: req=2'b11 after reset -> grant=01 first; after its message grant=10; next tie -> 01.
REQ-035 Non-interleave: req[1] rises mid requester-0 message -> grant stays 01 until last byte's busy falls.
REQ-036 Timeout: TIMEOUT=8, grant then valid held low -> abort pulse at 8th GRANT cycle, grant=0, pointer advanced.
REQ-037 Busy at grant: lcd_busy high when valid arrives -> data_ready stays low until busy falls, then byte issued unchanged.
REQ-038 Reset mid-WAIT_DONE -> next cycle all outputs zero, no accept, requester 0 wins next tie.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the two-requester LCD arbiter: requester count,
// FSM state encoding and a one-hot to index helper.
package lcd_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT     = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } lcd_state_e;

  // With two requesters the owner index is simply the upper bit of the one-hot grant.
  function automatic logic onehot_idx(input logic [NUM_REQ-1:0] oh);
    return oh[1];
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that was not served last wins.
module rr_pick2
  import lcd_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               pointer_i,
  output logic [NUM_REQ-1:0] choice_o
);

  // pointer_i holds the index of the requester served most recently.
  always_comb begin
    choice_o = '0;
    case (req_i)
      2'b01:   choice_o = 2'b01;
      2'b10:   choice_o = 2'b10;
      2'b11:   choice_o = pointer_i ? 2'b01 : 2'b10;
      default: choice_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/lcd_arbiter.sv
// Arbitrates two byte-stream requesters onto one LCD driver, one whole message
// per grant, with an idle timeout that revokes a stalled grant.
module lcd_arbiter
  import lcd_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic       clock,
  input  logic       internal_reset,
  input  logic [1:0] req,
  input  logic [1:0] valid,
  input  logic [1:0] last,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       rs0,
  input  logic       rs1,
  output logic [1:0] grant,
  output logic [1:0] accept,
  output logic       abort,
  input  logic       lcd_busy,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       data_ready
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  lcd_state_e state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    lcdData_q, lcdData_d;
  logic          lcdRs_q, lcdRs_d;
  logic          last_q, last_d;

  logic       owner;
  logic       ownerReq;
  logic       ownerValid;
  logic       ownerLast;
  logic [7:0] ownerData;
  logic       ownerRs;
  logic [1:0] pick;

  assign owner      = onehot_idx(grant_q);
  assign ownerReq   = req[owner];
  assign ownerValid = valid[owner];
  assign ownerLast  = last[owner];
  assign ownerData  = owner ? data1 : data0;
  assign ownerRs    = owner ? rs1 : rs0;

  rr_pick2 u_pick (
    .req_i     (req),
    .pointer_i (ptr_q),
    .choice_o  (pick)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    lcdData_d  = lcdData_q;
    lcdRs_d    = lcdRs_q;
    last_d     = last_q;
    accept     = 2'b00;
    abort      = 1'b0;
    data_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
          grant_d = pick;
          cnt_d   = '0;
        end
      end

      // A present byte takes precedence over the idle checks; the counter only
      // advances while the owner has nothing to offer.
      ST_GRANT: begin
        if (ownerValid) begin
          if (!lcd_busy) begin
            lcdData_d = ownerData;
            lcdRs_d   = ownerRs;
            last_d    = ownerLast;
            state_d   = ST_ISSUE;
          end
        end else if (!ownerReq || (cnt_q == CNT_MAX)) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
          grant_d = 2'b00;
          ptr_d   = owner;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_ISSUE: begin
        data_ready = 1'b1;
        if (lcd_busy) begin
          accept  = grant_q;
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (!lcd_busy) begin
          if (last_q) begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
            ptr_d   = owner;
          end else begin
            state_d = ST_GRANT;
            cnt_d   = '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clock) begin
    if (internal_reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'b00;
      ptr_q     <= 1'b1;
      cnt_q     <= '0;
      lcdData_q <= 8'h00;
      lcdRs_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      lcdData_q <= lcdData_d;
      lcdRs_q   <= lcdRs_d;
      last_q    <= last_d;
    end
  end

  assign grant    = grant_q;
  assign lcd_data = lcdData_q;
  assign lcd_rs   = lcdRs_q;

endmodule

// File: tb/tb_lcd_arbiter.sv
// Scoreboard bench for lcd_arbiter: requesters push expected bytes/aborts,
// a negedge monitor pops and compares them as the arbiter reports them.
module tb_lcd_arbiter;

  logic       clock = 1'b0;
  logic       internal_reset;
  logic [1:0] req, valid, last;
  logic [7:0] data0, data1;
  logic       rs0, rs1;
  logic [1:0] grant, accept;
  logic       abort;
  logic       lcd_busy;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       data_ready;

  typedef struct packed {
    logic       isAbort;
    logic [7:0] data;
    logic       rs;
  } evt_t;

  evt_t       expQ0[$];
  evt_t       expQ1[$];
  logic [1:0] grantLog[$];
  logic [1:0] prevGrant = 2'b00;

  int checks = 0;
  int errors = 0;

  logic autoBusy = 1'b1;
  int   busyLen  = 5;
  int   busyCnt  = 0;

  lcd_arbiter #(.TIMEOUT(8)) dut (
    .clock          (clock),
    .internal_reset (internal_reset),
    .req            (req),
    .valid          (valid),
    .last           (last),
    .data0          (data0),
    .data1          (data1),
    .rs0            (rs0),
    .rs1            (rs1),
    .grant          (grant),
    .accept         (accept),
    .abort          (abort),
    .lcd_busy       (lcd_busy),
    .lcd_data       (lcd_data),
    .lcd_rs         (lcd_rs),
    .data_ready     (data_ready)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int who, input logic isAbort, input logic [7:0] d, input logic r);
    evt_t e;
    e.isAbort = isAbort;
    e.data    = d;
    e.rs      = r;
    if (who == 0) expQ0.push_back(e);
    else          expQ1.push_back(e);
  endtask

  // Sends an n-byte message from requester who, waiting for each accept.
  task automatic applyStimulus(input int who, input int n, input logic [23:0] bytes, input logic [2:0] rss);
    for (int k = 0; k < n; k++) begin
      logic got;
      @(posedge clock); #1;
      req[who]   = 1'b1;
      valid[who] = 1'b1;
      last[who]  = (k == n - 1);
      if (who == 0) begin data0 = bytes[8*k +: 8]; rs0 = rss[k]; end
      else          begin data1 = bytes[8*k +: 8]; rs1 = rss[k]; end
      pushExp(who, 1'b0, bytes[8*k +: 8], rss[k]);
      got = 1'b0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clock);
        if (accept[who]) begin got = 1'b1; break; end
      end
      if (!got) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept wait req%0d byte%0d: got none expected accept", who, k);
      end
    end
    @(posedge clock); #1;
    req[who]   = 1'b0;
    valid[who] = 1'b0;
    last[who]  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulseReset();
    @(posedge clock); #1;
    internal_reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    internal_reset = 1'b0;
  endtask

  task automatic checkLog(input string name, input logic [1:0] g0, input logic [1:0] g1);
    checkOutput({name, " grant count"}, grantLog.size(), 2);
    if (grantLog.size() >= 2) begin
      checkOutput({name, " first grant"}, {30'd0, grantLog[0]}, {30'd0, g0});
      checkOutput({name, " second grant"}, {30'd0, grantLog[1]}, {30'd0, g1});
    end
  endtask

  // LCD driver model: goes busy for busyLen cycles whenever a byte is offered.
  initial begin
    lcd_busy = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (autoBusy) begin
        if (busyCnt > 0) begin
          busyCnt--;
          if (busyCnt == 0) lcd_busy = 1'b0;
        end else if (data_ready && !lcd_busy) begin
          lcd_busy = 1'b1;
          busyCnt  = busyLen;
        end
      end
    end
  end

  // Monitor: pops the owner's queue on every accept or abort.
  initial begin
    forever begin
      evt_t e;
      logic have;
      @(negedge clock);
      if (grant != prevGrant && grant != 2'b00) grantLog.push_back(grant);
      prevGrant = grant;
      if (accept != 2'b00) begin
        have = 1'b0;
        e    = '0;
        if (accept == 2'b11) begin
          checks++; errors++;
          $display("[TB] FAIL accept onehot: got %b expected single bit", accept);
        end else if (accept[1]) begin
          have = (expQ1.size() != 0);
          if (have) e = expQ1.pop_front();
        end else begin
          have = (expQ0.size() != 0);
          if (have) e = expQ0.pop_front();
        end
        checks++;
        if (!have) begin
          errors++;
          $display("[TB] FAIL accept byte: got unexpected accept %b expected none", accept);
        end else if (e.isAbort || lcd_data !== e.data || lcd_rs !== e.rs) begin
          errors++;
          $display("[TB] FAIL accept byte: got data %h rs %b expected data %h rs %b abort %b",
                   lcd_data, lcd_rs, e.data, e.rs, e.isAbort);
        end
        checkOutput("accept owner/data_ready", {29'd0, data_ready, grant}, {29'd0, 1'b1, accept});
      end
      if (abort) begin
        checks++;
        have = 1'b0;
        e    = '0;
        if (grant == 2'b10) begin
          have = (expQ1.size() != 0);
          if (have) e = expQ1.pop_front();
        end else if (grant == 2'b01) begin
          have = (expQ0.size() != 0);
          if (have) e = expQ0.pop_front();
        end
        if (!have || !e.isAbort) begin
          errors++;
          $display("[TB] FAIL abort event: got abort with grant %b expected queued abort", grant);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  seenAt;
    logic got;
    internal_reset = 1'b1;
    req = 2'b00; valid = 2'b00; last = 2'b00;
    data0 = 8'h00; data1 = 8'h00; rs0 = 1'b0; rs1 = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset grant", {30'd0, grant}, 0);
    checkOutput("reset accept/abort", {29'd0, accept, abort}, 0);
    checkOutput("reset data_ready", {31'd0, data_ready}, 0);
    checkOutput("reset lcd_data/rs", {23'd0, lcd_data, lcd_rs}, 0);
    @(posedge clock); #1;
    internal_reset = 1'b0;

    // Single three-byte message with latency check.
    grantLog.delete();
    fork
      applyStimulus(0, 3, {8'h41, 8'h0C, 8'h38}, 3'b100);
      begin
        @(posedge clock);
        @(negedge clock);
        @(negedge clock);
        checkOutput("latency grant cycle", {29'd0, data_ready, grant}, {29'd0, 1'b0, 2'b01});
        @(negedge clock);
        checkOutput("latency issue cycle", {31'd0, data_ready}, 1);
      end
    join
    idleCycles(10);
    checkOutput("single message grant idle", {30'd0, grant}, 0);

    // Contention from reset: requester 0 first, then 1, then 0 again on the next tie.
    pulseReset();
    grantLog.delete();
    fork
      applyStimulus(0, 2, {8'h00, 8'h22, 8'h11}, 3'b010);
      applyStimulus(1, 2, {8'h00, 8'hB2, 8'hB1}, 3'b001);
    join
    idleCycles(10);
    checkLog("contention", 2'b01, 2'b10);
    grantLog.delete();
    fork
      applyStimulus(0, 1, {16'h0, 8'h33}, 3'b000);
      applyStimulus(1, 1, {16'h0, 8'hC3}, 3'b001);
    join
    idleCycles(10);
    checkLog("second tie", 2'b01, 2'b10);

    // Requester 1 arrives mid-message and must wait for the whole message.
    grantLog.delete();
    fork
      applyStimulus(0, 3, {8'h5C, 8'h5B, 8'h5A}, 3'b101);
      begin
        got = 1'b0;
        for (int c = 0; c < 400; c++) begin
          @(negedge clock);
          if (accept[0]) begin got = 1'b1; break; end
        end
        checkOutput("interleave first accept", {31'd0, got}, 1);
        applyStimulus(1, 1, {16'h0, 8'hE1}, 3'b000);
      end
    join
    idleCycles(10);
    checkLog("non-interleave", 2'b01, 2'b10);

    // Timeout: grant held with valid low for TIMEOUT cycles.
    pushExp(0, 1'b1, 8'h00, 1'b0);
    @(posedge clock); #1;
    req[0] = 1'b1; valid[0] = 1'b0;
    seenAt = -1;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clock);
      if (abort) begin seenAt = c; break; end
    end
    checkOutput("timeout abort cycle", seenAt, 8);
    @(posedge clock); #1;
    req[0] = 1'b0;
    @(negedge clock);
    checkOutput("timeout grant cleared", {30'd0, grant}, 0);
    idleCycles(3);
    grantLog.delete();
    fork
      applyStimulus(0, 1, {16'h0, 8'h44}, 3'b001);
      applyStimulus(1, 1, {16'h0, 8'hD4}, 3'b000);
    join
    idleCycles(10);
    checkLog("tie after timeout", 2'b10, 2'b01);

    // Request dropped while granted with no byte pending.
    pushExp(1, 1'b1, 8'h00, 1'b0);
    @(posedge clock); #1;
    req[1] = 1'b1; valid[1] = 1'b0;
    @(posedge clock); #1;
    req[1] = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (abort) begin got = 1'b1; break; end
    end
    checkOutput("req drop abort seen", {31'd0, got}, 1);
    @(negedge clock);
    checkOutput("req drop grant cleared", {30'd0, grant}, 0);
    idleCycles(3);

    // LCD busy when the byte arrives: nothing issued until busy falls.
    autoBusy = 1'b0;
    lcd_busy = 1'b1;
    fork
      applyStimulus(0, 1, {16'h0, 8'h55}, 3'b001);
      begin
        @(posedge clock);
        for (int c = 0; c < 6; c++) begin
          @(negedge clock);
          checkOutput("busy hold data_ready", {31'd0, data_ready}, 0);
        end
        @(posedge clock); #1;
        lcd_busy = 1'b0;
        autoBusy = 1'b1;
      end
    join
    idleCycles(10);

    // Reset while waiting for the driver: everything clears, pointer restored.
    pushExp(0, 1'b0, 8'h12, 1'b1);
    @(posedge clock); #1;
    req[0] = 1'b1; valid[0] = 1'b1; last[0] = 1'b0; data0 = 8'h12; rs0 = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (accept[0]) begin got = 1'b1; break; end
    end
    checkOutput("reset test accept seen", {31'd0, got}, 1);
    @(posedge clock); #1;
    internal_reset = 1'b1;
    req[0] = 1'b0; valid[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("mid-wait reset outputs",
                {20'd0, grant, accept, abort, data_ready, lcd_data, lcd_rs}, 0);
    repeat (8) @(posedge clock);
    #1;
    internal_reset = 1'b0;
    grantLog.delete();
    fork
      applyStimulus(0, 1, {16'h0, 8'h66}, 3'b000);
      applyStimulus(1, 1, {16'h0, 8'hF6}, 3'b001);
    join
    idleCycles(10);
    checkLog("tie after reset", 2'b01, 2'b10);

    checkOutput("queue0 drained", expQ0.size(), 0);
    checkOutput("queue1 drained", expQ1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
